pulse_timer: RTL and testbench
==============================

# pulse_timer

Multi-channel programmable pulse generator; successor to the fixed-parameter delay, pulse-delay and pulse-stretch utilities. Each channel turns a one-cycle trigger into a single output pulse. The pulse has a run-time programmable delay and width, so one instance can replace chains of delay/stretch cells. Typical uses are PPS-derived strobes, LED/display blanking windows and DAC/latch enables.

## Interface
- `CHANNELS`, 4: number of independent channels; must be ≥1.
- `DLY_W`, 8: width of the per-channel delay value; must be ≥1.
- `WID_W`, 8: width of the per-channel pulse-width value; must be ≥1.
- `RETRIG`, 0: 0 ignores triggers while a channel is busy; 1 restarts the channel on such triggers.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `trig`  in  CHANNELS  per-channel trigger; sampled every cycle, level = one trigger per cycle high.
- `dly`  in  CHANNELS*DLY_W  packed delays; channel i uses bits [i*DLY_W +: DLY_W].
- `wid`  in  CHANNELS*WID_W  packed widths; channel i uses bits [i*WID_W +: WID_W].
- `q`  out  CHANNELS  registered pulse outputs.
- `busy`  out  CHANNELS  registered; high while the channel is not IDLE.
- `ovr_clr`  in  1  clears all overrun flags (present only with `PULSE_TIMER_OVR_EN`).
- `ovr`  out  CHANNELS  sticky overrun flags (present only with `PULSE_TIMER_OVR_EN`).

## Operation
- Each channel is independent and has states IDLE, DELAY and ACTIVE, a DLY_W-bit delay counter and a WID_W-bit width counter.
- `dly`/`wid` are sampled only on an accepted trigger. Later changes do not affect a pulse in flight.
- **IDLE** (q=0, busy=0), on trig=1:
  - wid=0: the trigger is discarded and the channel stays IDLE. This is not an overrun.
  - dly=0: go to ACTIVE and load the width counter with wid.
  - otherwise: go to DELAY and load the delay counter with dly.
- **DELAY**: decrement the delay counter each cycle. On the transition past 1, go to ACTIVE and load the width counter with the latched wid.
- **ACTIVE** (q=1): decrement the width counter each cycle. On the transition past 1, go to IDLE.
- **Trigger while busy**:
  - RETRIG=0: the trigger is ignored.
  - RETRIG=1: the trigger is handled exactly as from IDLE, using the newly sampled dly/wid. The current pulse is abandoned, so q drops if the new dly>0. A retrigger with wid=0 forces the channel to IDLE.
- Counters never wrap. Maximum delay is 2^DLY_W−1 cycles; maximum width is 2^WID_W−1 cycles.
- Reset: all channels go to IDLE with q=0, busy=0 and ovr=0, one cycle after the `rst` edge. This includes a reset that arrives mid-pulse. Triggers coincident with rst are dropped.

## Timing
- A trigger accepted in cycle T with delay d and width w gives q=1 in cycles T+1+d through T+d+w inclusive: exactly w cycles.
- busy=1 in cycles T+1 through T+d+w.
- Latency from trigger to q rising is d+1 cycles.
- The minimum spacing between accepted triggers with RETRIG=0 is d+w+1 cycles. A trigger in cycle T+d+w (the last busy cycle) is treated as a busy trigger.
- A retrigger in cycle T′ follows the same equations, with T′ replacing T.
- Channels produce no cross-channel interaction, and simultaneous triggers on all channels are fully supported.

## Configuration
- `PULSE_TIMER_OVR_EN` defined:
  - Adds the `ovr_clr` and `ovr` ports.
  - ovr[i] is set in the cycle after channel i sees trig=1 while busy=1. This applies in both RETRIG modes, provided wid≠0.
  - ovr[i] stays high until the cycle after `ovr_clr`=1. If set and clear occur in the same cycle, set wins.
- Undefined: the ports and the flag logic are absent. All other behaviour is identical.

## Test plan
- CHANNELS=4, dly=3, wid=5, trig on ch0 at cycle 10 -> busy in cycles 11–18, q in cycles 14–18, other channels stay 0.
- dly=0, wid=1, trig at cycle 5 -> a single-cycle q in cycle 6. Then wid=0 with a trigger -> q and busy stay 0, and ovr is not set.
- RETRIG=0, dly=2, wid=4, triggers at 10 and 13 -> one pulse in cycles 13–16; the second trigger is ignored; ovr[0]=1 from cycle 14; ovr_clr at cycle 20 -> ovr=0 at cycle 21.
- RETRIG=1, dly=2, wid=4, trigger at 10, retrigger at 14 with dly=1, wid=2 -> q=1 in cycle 13–14, 0 in cycle 15, 1 in cycles 16–17, busy through cycle 17.
- rst asserted at cycle 15 during an ACTIVE pulse -> q, busy and ovr all 0 from cycle 16. A trigger at cycle 20 then behaves as from power-up.
- All channels triggered in the same cycle, each with a different dly and wid, including max values dly=255 and wid=255 -> each channel's q matches the timing equations independently.

Source files
------------

// File: rtl/pulse_timer.sv
// pulse_timer: per-channel trigger -> one pulse, q rises d+1 cycles after trigger and lasts wid cycles.
// No backpressure: busy triggers are ignored or restart the channel (RETRIG); PULSE_TIMER_OVR_EN adds ovr/ovr_clr.
module pulse_timer #(
  parameter int CHANNELS = 4,
  parameter int DLY_W    = 8,
  parameter int WID_W    = 8,
  parameter int RETRIG   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       trig,
  input  logic [CHANNELS*DLY_W-1:0] dly,
  input  logic [CHANNELS*WID_W-1:0] wid,
`ifdef PULSE_TIMER_OVR_EN
  input  logic                      ovr_clr,
  output logic [CHANNELS-1:0]       ovr,
`endif
  output logic [CHANNELS-1:0]       q,
  output logic [CHANNELS-1:0]       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam bit RETRIG_EN = (RETRIG != 0);

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      state_t           state;
      state_t           state_nxt;
      logic [DLY_W-1:0] dcnt;
      logic [DLY_W-1:0] dcnt_nxt;
      logic [WID_W-1:0] wcnt;
      logic [WID_W-1:0] wcnt_nxt;
      logic [WID_W-1:0] wlat;
      logic [WID_W-1:0] wlat_nxt;
      logic [DLY_W-1:0] d_in;
      logic [WID_W-1:0] w_in;
      logic             accept;
      logic             q_r;
      logic             busy_r;

      assign d_in = dly[i*DLY_W +: DLY_W];
      assign w_in = wid[i*WID_W +: WID_W];

      always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        wcnt_nxt  = wcnt;
        wlat_nxt  = wlat;
        accept    = trig[i] && ((state == IDLE) || RETRIG_EN);

        case (state)
          DELAY: begin
            if (dcnt == DLY_W'(1)) begin
              state_nxt = ACTIVE;
              wcnt_nxt  = wlat;
            end else begin
              dcnt_nxt = dcnt - DLY_W'(1);
            end
          end
          ACTIVE: begin
            if (wcnt == WID_W'(1)) begin
              state_nxt = IDLE;
            end else begin
              wcnt_nxt = wcnt - WID_W'(1);
            end
          end
          default: ;
        endcase

        // An accepted trigger overrides the countdown; a zero width abandons any pulse.
        if (accept) begin
          if (w_in == '0) begin
            state_nxt = IDLE;
          end else if (d_in == '0) begin
            state_nxt = ACTIVE;
            wcnt_nxt  = w_in;
          end else begin
            state_nxt = DELAY;
            dcnt_nxt  = d_in;
            wlat_nxt  = w_in;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state  <= IDLE;
          dcnt   <= '0;
          wcnt   <= '0;
          wlat   <= '0;
          q_r    <= 1'b0;
          busy_r <= 1'b0;
        end else begin
          state  <= state_nxt;
          dcnt   <= dcnt_nxt;
          wcnt   <= wcnt_nxt;
          wlat   <= wlat_nxt;
          q_r    <= (state_nxt == ACTIVE);
          busy_r <= (state_nxt != IDLE);
        end
      end

      assign q[i]    = q_r;
      assign busy[i] = busy_r;

`ifdef PULSE_TIMER_OVR_EN
      logic ovr_r;

      // Set has priority over clear so a same-cycle overrun is never lost.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovr_r <= 1'b0;
        end else if (trig[i] && busy_r && (w_in != '0)) begin
          ovr_r <= 1'b1;
        end else if (ovr_clr) begin
          ovr_r <= 1'b0;
        end
      end

      assign ovr[i] = ovr_r;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_pulse_timer.sv
// Bench for pulse_timer: one instance per RETRIG mode, checked every cycle against a timestamp model.
module tb_pulse_timer;
  localparam int CH = 4;
  localparam int DW = 8;
  localparam int WW = 8;
`ifdef PULSE_TIMER_OVR_EN
  localparam int OW = 6*CH;
`else
  localparam int OW = 4*CH;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [CH-1:0]  trig = '0;
  logic [CH*DW-1:0] dly = '0;
  logic [CH*WW-1:0] wid = '0;
  logic           ovr_clr = 1'b0;
  logic [CH-1:0]  q0, busy0, q1, busy1;
  logic [CH-1:0]  ovr0, ovr1;
  logic [OW-1:0]  obs;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: each channel remembers its last accepted trigger cycle and its d/w.
  int t0[2][CH];
  int dd[2][CH];
  int ww[2][CH];
  bit act[2][CH];
  bit ov[2][CH];

  always #5 clk = ~clk;

  pulse_timer #(.CHANNELS(CH), .DLY_W(DW), .WID_W(WW), .RETRIG(0)) dut0 (
    .clk(clk), .rst(rst), .trig(trig), .dly(dly), .wid(wid),
`ifdef PULSE_TIMER_OVR_EN
    .ovr_clr(ovr_clr), .ovr(ovr0),
`endif
    .q(q0), .busy(busy0)
  );

  pulse_timer #(.CHANNELS(CH), .DLY_W(DW), .WID_W(WW), .RETRIG(1)) dut1 (
    .clk(clk), .rst(rst), .trig(trig), .dly(dly), .wid(wid),
`ifdef PULSE_TIMER_OVR_EN
    .ovr_clr(ovr_clr), .ovr(ovr1),
`endif
    .q(q1), .busy(busy1)
  );

`ifdef PULSE_TIMER_OVR_EN
  assign obs = {q0, busy0, ovr0, q1, busy1, ovr1};
`else
  assign ovr0 = '0;
  assign ovr1 = '0;
  assign obs = {q0, busy0, q1, busy1};
`endif

  function automatic bit m_busy(int m, int ch, int c);
    return act[m][ch] && (c >= t0[m][ch] + 1) && (c <= t0[m][ch] + dd[m][ch] + ww[m][ch]);
  endfunction

  function automatic bit m_q(int m, int ch, int c);
    return act[m][ch] && (c >= t0[m][ch] + 1 + dd[m][ch]) && (c <= t0[m][ch] + dd[m][ch] + ww[m][ch]);
  endfunction

  function automatic logic [OW-1:0] expect_all();
    logic [CH-1:0] eq [2];
    logic [CH-1:0] eb [2];
    logic [CH-1:0] eo [2];
    for (int m = 0; m < 2; m++)
      for (int ch = 0; ch < CH; ch++) begin
        eq[m][ch] = m_q(m, ch, cyc);
        eb[m][ch] = m_busy(m, ch, cyc);
        eo[m][ch] = ov[m][ch];
      end
`ifdef PULSE_TIMER_OVR_EN
    return {eq[0], eb[0], eo[0], eq[1], eb[1], eo[1]};
`else
    return {eq[0], eb[0], eq[1], eb[1]};
`endif
  endfunction

  // Clocks one edge, applies the spec rules to the model, then releases one-shot inputs.
  task automatic advance();
    @(posedge clk);
    for (int m = 0; m < 2; m++)
      for (int ch = 0; ch < CH; ch++) begin
        if (rst) begin
          act[m][ch] = 1'b0;
          ov[m][ch]  = 1'b0;
        end else begin
          bit b;
          bit setv;
          int dv;
          int wv;
          b    = m_busy(m, ch, cyc);
          dv   = int'(dly[ch*DW +: DW]);
          wv   = int'(wid[ch*WW +: WW]);
          setv = trig[ch] && b && (wv != 0);
          if (trig[ch] && (!b || m == 1)) begin
            if (wv == 0) act[m][ch] = 1'b0;
            else begin
              act[m][ch] = 1'b1;
              t0[m][ch]  = cyc;
              dd[m][ch]  = dv;
              ww[m][ch]  = wv;
            end
          end
          if (setv) ov[m][ch] = 1'b1;
          else if (ovr_clr) ov[m][ch] = 1'b0;
        end
      end
    cyc++;
    #1;
    trig    = '0;
    ovr_clr = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic set_dw(int ch, int d, int w);
    dly[ch*DW +: DW] = DW'(d);
    wid[ch*WW +: WW] = WW'(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trig = '1;
    set_dw(0, 0, 3);
    advance();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_state cyc=%0d got=%h exp=0", cyc, obs);
    end
    for (int k = 0; k < 3; k++) begin
      advance();
      checks++;
      if (obs !== expect_all()) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, expect_all());
      end
    end
  endtask

  task automatic test_basic();
    for (int ch = 0; ch < CH; ch++) set_dw(ch, 1, 1);
    set_dw(0, 3, 5);
    trig[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      advance();
      checks++;
      if (obs !== expect_all()) begin
        failures++;
        $display("FAIL basic_pulse cyc=%0d got=%h exp=%h", cyc, obs, expect_all());
      end
    end
    checks++;
    if ({q1[3:1], busy1[3:1], q0[3:1], busy0[3:1]} !== '0) begin
      failures++;
      $display("FAIL basic_isolation got=%h exp=0", {q1[3:1], busy1[3:1], q0[3:1], busy0[3:1]});
    end
  endtask

  task automatic test_zero();
    set_dw(1, 0, 1);
    trig[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      advance();
      checks++;
      if (obs !== expect_all()) begin
        failures++;
        $display("FAIL dly0_wid1 cyc=%0d got=%h exp=%h", cyc, obs, expect_all());
      end
    end
    set_dw(1, 2, 0);
    trig[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      advance();
      checks++;
      if (obs !== expect_all()) begin
        failures++;
        $display("FAIL wid0_discard cyc=%0d got=%h exp=%h", cyc, obs, expect_all());
      end
    end
  endtask

  task automatic test_overlap();
    set_dw(0, 2, 4);
    trig[0] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k == 2) trig[0] = 1'b1;
      if (k == 6) begin trig[0] = 1'b1; ovr_clr = 1'b1; end
      if (k == 9) ovr_clr = 1'b1;
      advance();
      checks++;
      if (obs !== expect_all()) begin
        failures++;
        $display("FAIL overlap cyc=%0d got=%h exp=%h", cyc, obs, expect_all());
      end
    end
    ovr_clr = 1'b1;
    advance();
  endtask

  task automatic test_retrig();
    set_dw(2, 2, 4);
    trig[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) begin set_dw(2, 1, 2); trig[2] = 1'b1; end
      if (k == 10) begin set_dw(2, 3, 0); trig[2] = 1'b1; end
      if (k == 8) begin set_dw(2, 5, 5); trig[2] = 1'b1; end
      advance();
      checks++;
      if (obs !== expect_all()) begin
        failures++;
        $display("FAIL retrig cyc=%0d got=%h exp=%h", cyc, obs, expect_all());
      end
    end
    for (int k = 0; k < 8; k++) advance();
  endtask

  task automatic test_reset_mid();
    set_dw(0, 1, 6);
    trig[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) trig[0] = 1'b1;
      if (k == 4) rst = 1'b1;
      if (k == 6) trig[0] = 1'b1;
      advance();
      checks++;
      if (obs !== expect_all()) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, obs, expect_all());
      end
    end
  endtask

  task automatic test_all_max();
    set_dw(0, 0, 7);
    set_dw(1, 255, 1);
    set_dw(2, 9, 255);
    set_dw(3, 255, 255);
    trig = '1;
    for (int k = 0; k < 515; k++) begin
      advance();
      checks++;
      if (obs !== expect_all()) begin
        failures++;
        $display("FAIL all_max cyc=%0d got=%h exp=%h", cyc, obs, expect_all());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      for (int ch = 0; ch < CH; ch++) begin
        trig[ch] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 40) == 0) set_dw(ch, $urandom_range(0, 255), $urandom_range(0, 40));
        else set_dw(ch, $urandom_range(0, 6), $urandom_range(0, 6));
      end
      ovr_clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 250) == 0);
      advance();
      checks++;
      if (obs !== expect_all()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expect_all());
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++)
      for (int ch = 0; ch < CH; ch++) begin
        t0[m][ch] = 0; dd[m][ch] = 0; ww[m][ch] = 0;
        act[m][ch] = 1'b0; ov[m][ch] = 1'b0;
      end
    test_reset();
    test_basic();
    test_zero();
    test_overlap();
    test_retrig();
    test_reset_mid();
    test_all_max();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
